// File: rtl/mult_pipe_axis.sv
// mult_pipe_axis: pipelined A_W x B_W multiplier with AXI-Stream style
// valid/ready on both sides, a sideband tag and a selectable output window.
//
// Optional feature macro: MULT_PIPE_ROUND_EN
//   defined   -> round half up: (P + 2^(SHIFT-1)) windowed at [SHIFT +: OUT_W]
//   undefined -> plain truncation, no rounding adder
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high. The whole pipe advances on ce = ~m_axis_tvalid | m_axis_tready, and
// s_axis_tready is exactly ce. Once m_axis_tvalid is high, data and tag stay
// frozen until m_axis_tready is seen high.
//
// Stage map: stage 1 holds the registered operands. Stage 2 holds the
// windowed product. Stages 3..LAT are plain delay registers that the tools
// may retime back into the multiplier. Stage LAT drives the m_axis_* ports.
module mult_pipe_axis #(
  parameter int A_W    = 32,
  parameter int B_W    = 32,
  parameter int SIGNED = 0,
  parameter int LAT    = 6,
  parameter int OUT_W  = 64,
  parameter int SHIFT  = 0,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [A_W-1:0]   s_axis_tdata_a,
  input  logic [B_W-1:0]   s_axis_tdata_b,
  input  logic [TAG_W-1:0] s_axis_ttag,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic [TAG_W-1:0] m_axis_ttag,
  output logic             busy
);

`ifdef MULT_PIPE_ROUND_EN
  // One extra bit so the rounding carry out of the full product is kept.
  localparam int P_W = A_W + B_W + 1;
`else
  localparam int P_W = A_W + B_W;
`endif

  logic                 w_ce;
  logic [LAT:1]         r_v;
  logic [A_W-1:0]       r_a;
  logic [B_W-1:0]       r_b;
  logic [TAG_W-1:0]     r_tag [1:LAT];
  logic [OUT_W-1:0]     r_d   [2:LAT];
  logic [P_W-1:0]       w_ext_a;
  logic [P_W-1:0]       w_ext_b;
  logic [P_W-1:0]       w_prod;
  logic [OUT_W-1:0]     w_win;

  // Global enable: the pipe moves unless the output is holding an unconsumed beat.
  assign w_ce          = ~r_v[LAT] | m_axis_tready;
  assign s_axis_tready = w_ce;

  // Operand extension: sign bit replicated only for signed operation.
  assign w_ext_a = {{(P_W - A_W){(SIGNED != 0) & r_a[A_W-1]}}, r_a};
  assign w_ext_b = {{(P_W - B_W){(SIGNED != 0) & r_b[B_W-1]}}, r_b};

  // Low P_W bits of the extended product equal the two's-complement product.
  assign w_prod = w_ext_a * w_ext_b;

`ifdef MULT_PIPE_ROUND_EN
  // Half an output LSB; zero when nothing is dropped, so SHIFT = 0 is pure truncation.
  localparam logic [P_W-1:0] RND =
    (SHIFT > 0) ? (P_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  logic [P_W-1:0] w_sum;
  assign w_sum = w_prod + RND;
  assign w_win = OUT_W'(w_sum >> SHIFT);
`else
  assign w_win = OUT_W'(w_prod >> SHIFT);
`endif

  // Valid chain: stage 1 takes s_axis_tvalid, every stage shifts only on ce.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v <= '0;
    end else if (w_ce) begin
      r_v <= {r_v[LAT-1:1], s_axis_tvalid};
    end
  end

  // Stage 1 operand registers, loaded on every enabled edge (idle or not).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_ce) begin
      r_a <= s_axis_tdata_a;
      r_b <= s_axis_tdata_b;
    end
  end

  // Tag delay line, kept in lock-step with the valid chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i <= LAT; i++) r_tag[i] <= '0;
    end else if (w_ce) begin
      r_tag[1] <= s_axis_ttag;
      for (int i = 2; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Product stages: stage 2 captures the windowed product, later stages delay it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 2; i <= LAT; i++) r_d[i] <= '0;
    end else if (w_ce) begin
      r_d[2] <= w_win;
      for (int i = 3; i <= LAT; i++) r_d[i] <= r_d[i-1];
    end
  end

  assign m_axis_tvalid = r_v[LAT];
  assign m_axis_tdata  = r_d[LAT];
  assign m_axis_ttag   = r_tag[LAT];
  assign busy          = |r_v;

endmodule
